// File: rtl/mod_ring_divider_pkg.sv
// Shared helpers for the rotating-ring clock divider: reset pattern, popcount width, parameter legality.
package mod_ring_divider_pkg;

    localparam int unsigned MAX_DIV_N = 256;

    // Ones in the low HIGH_CNT positions; the caller truncates to its ring width.
    function automatic logic [MAX_DIV_N-1:0] reset_pattern(input int unsigned div_n,
                                                          input int unsigned high_cnt);
        logic [MAX_DIV_N-1:0] p;
        p = '0;
        for (int unsigned i = 0; i < MAX_DIV_N; i++) begin
            if ((i < high_cnt) && (i < div_n)) begin
                p[i] = 1'b1;
            end
        end
        return p;
    endfunction

    function automatic int unsigned popcount_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

    function automatic bit params_legal(input int unsigned div_n, input int unsigned high_cnt);
        return (div_n >= 2) && (div_n <= MAX_DIV_N) && (high_cnt >= 1) && (high_cnt < div_n);
    endfunction

endpackage

// File: rtl/mod_ring_popcount.sv
// Combinational population count of a W-bit vector.
module mod_ring_popcount
    import mod_ring_divider_pkg::*;
#(
    parameter int unsigned W  = 4,
    parameter int unsigned CW = popcount_width(W)
) (
    input  logic [W-1:0]  vec,
    output logic [CW-1:0] count
);

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < W; i++) begin
            count = count + CW'(vec[i]);
        end
    end

endmodule

// File: rtl/mod_ring_divider.sv
// Divide-by-DIV_N clock/enable generator from a rotating ring preloaded with HIGH_CNT ones.
// Optional MOD_RING_SELF_CORRECT_EN reloads the ring when its ones count is corrupted.
module mod_ring_divider
    import mod_ring_divider_pkg::*;
#(
    parameter int unsigned DIV_N    = 4,
    parameter int unsigned HIGH_CNT = DIV_N / 2
) (
    input  logic clk,
    input  logic rst,
    output logic q_out
);

    if (!params_legal(DIV_N, HIGH_CNT)) begin : g_illegal_params
        $error("mod_ring_divider: illegal DIV_N=%0d HIGH_CNT=%0d", DIV_N, HIGH_CNT);
    end

    localparam logic [DIV_N-1:0] RESET_P = DIV_N'(reset_pattern(DIV_N, HIGH_CNT));

    logic [DIV_N-1:0] r;
    logic             corrupt_c;

`ifdef MOD_RING_SELF_CORRECT_EN
    localparam int unsigned CW = popcount_width(DIV_N);

    logic [CW-1:0] ones_c;

    mod_ring_popcount #(
        .W  (DIV_N),
        .CW (CW)
    ) u_popcount (
        .vec   (r),
        .count (ones_c)
    );

    // A ring that no longer holds exactly HIGH_CNT ones is restarted from phase 0.
    assign corrupt_c = (ones_c != CW'(HIGH_CNT));
`else
    assign corrupt_c = 1'b0;
`endif

    // Reset has priority over correction; otherwise rotate left.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r <= RESET_P;
        end else if (corrupt_c) begin
            r <= RESET_P;
        end else begin
            r <= {r[DIV_N-2:0], r[DIV_N-1]};
        end
    end

    assign q_out = r[DIV_N-1];

endmodule

// File: tb/tb_mod_ring_divider.sv
// Self-checking bench for mod_ring_divider: directed vector table, corruption sequence, parameter sweep.
module tb_mod_ring_divider;

    localparam int unsigned N_SWEEP = 28;
    localparam int unsigned N_HIST  = 31;

    logic clk;
    logic rst;
    logic q_out;
    logic sw_rst;
    logic [N_SWEEP-1:0] q_sweep;

    int n_checks;
    int n_fail;

    mod_ring_divider dut (
        .clk   (clk),
        .rst   (rst),
        .q_out (q_out)
    );

    for (genvar d = 2; d <= 8; d++) begin : g_div
        for (genvar h = 1; h < d; h++) begin : g_high
            mod_ring_divider #(
                .DIV_N    (d),
                .HIGH_CNT (h)
            ) u_sweep (
                .clk   (clk),
                .rst   (sw_rst),
                .q_out (q_sweep[(d-2)*(d-1)/2 + h - 1])
            );
        end
    end

    initial clk = 1'b0;
    always #2 clk = ~clk;

    typedef struct packed {
        logic       rst_v;
        logic       q_exp;
        logic [3:0] r_exp;
    } vec_t;

    vec_t tbl [17];
    logic [N_SWEEP-1:0] hist [N_HIST];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic rst_v);
        @(negedge clk);
        rst = rst_v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] r_seq [8];
        logic       q_seq [8];
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        sw_rst   = 1'b0;

        // T2/T4 waveform of the default 4-stage ring, including resets while high and mid-period.
        tbl[0]  = '{1'b1, 1'b0, 4'b0110};
        tbl[1]  = '{1'b1, 1'b1, 4'b1100};
        tbl[2]  = '{1'b1, 1'b1, 4'b1001};
        tbl[3]  = '{1'b1, 1'b0, 4'b0011};
        tbl[4]  = '{1'b1, 1'b0, 4'b0110};
        tbl[5]  = '{1'b1, 1'b1, 4'b1100};
        tbl[6]  = '{1'b0, 1'b0, 4'b0011};
        tbl[7]  = '{1'b1, 1'b0, 4'b0110};
        tbl[8]  = '{1'b1, 1'b1, 4'b1100};
        tbl[9]  = '{1'b1, 1'b1, 4'b1001};
        tbl[10] = '{1'b0, 1'b0, 4'b0011};
        tbl[11] = '{1'b1, 1'b0, 4'b0110};
        tbl[12] = '{1'b1, 1'b1, 4'b1100};
        tbl[13] = '{1'b0, 1'b0, 4'b0011};
        tbl[14] = '{1'b0, 1'b0, 4'b0011};
        tbl[15] = '{1'b1, 1'b0, 4'b0110};
        tbl[16] = '{1'b1, 1'b1, 4'b1100};

        // T1: first edge with rst low loads the reset pattern
        @(posedge clk);
        #1;
        check("reset_q", 32'(q_out), 32'd0);
        check("reset_r", 32'(dut.r), 32'b0011);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("release_q", 32'(q_out), 32'd0);
        check("release_r", 32'(dut.r), 32'b0110);
        step(1'b0);

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].rst_v);
            check($sformatf("vec%0d_q", i), 32'(q_out), 32'(tbl[i].q_exp));
            check($sformatf("vec%0d_r", i), 32'(dut.r), 32'(tbl[i].r_exp));
        end

        // T5: corrupt the ring to three ones between edges
        step(1'b0);
        step(1'b1);
        @(negedge clk);
        force dut.r = 4'b0111;
        #1;
        release dut.r;
`ifdef MOD_RING_SELF_CORRECT_EN
        r_seq = '{4'b0011, 4'b0110, 4'b1100, 4'b1001, 4'b0011, 4'b0110, 4'b1100, 4'b1001};
        q_seq = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
`else
        r_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
        q_seq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
`endif
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step(1'b1);
            check($sformatf("corrupt%0d_r", i), 32'(dut.r), 32'(r_seq[i]));
            check($sformatf("corrupt%0d_q", i), 32'(q_out), 32'(q_seq[i]));
        end

        // T6: sweep instances held in reset until now; record waveforms after release
        @(negedge clk);
        hist[0] = q_sweep;
        sw_rst  = 1'b1;
        for (int k = 1; k < int'(N_HIST); k++) begin
            @(posedge clk);
            #1;
            hist[k] = q_sweep;
        end

        for (int d = 2; d <= 8; d++) begin
            for (int h = 1; h < d; h++) begin
                int idx;
                int highs;
                int rise1;
                int rise2;
                idx   = (d - 2) * (d - 1) / 2 + h - 1;
                highs = 0;
                rise1 = -1;
                rise2 = -1;
                for (int k = 1; k <= 3 * d; k++) begin
                    if (hist[k][idx] === 1'b1) highs++;
                end
                for (int k = 1; k < int'(N_HIST); k++) begin
                    if (hist[k][idx] === 1'b1 && hist[k-1][idx] === 1'b0) begin
                        if (rise1 < 0) rise1 = k;
                        else if (rise2 < 0) rise2 = k;
                    end
                end
                check($sformatf("sweep_d%0d_h%0d_high", d, h), 32'(highs), 32'(3 * h));
                check($sformatf("sweep_d%0d_h%0d_period", d, h),
                      32'((rise1 < 0 || rise2 < 0) ? 0 : rise2 - rise1), 32'(d));
                check($sformatf("sweep_d%0d_h%0d_first_rise", d, h), 32'(rise1), 32'(d - h));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
